// File: rtl/text_memory_prefetch_interface_pkg.sv
// Shared types and defaults for the sequential instruction prefetcher.
// The reset PC and buffer sizing live here so the core and the bench agree on them.
package text_memory_prefetch_interface_pkg;

    typedef logic [31:0] word_t;

    localparam word_t INITIAL_PC               = 32'h0040_0000;
    localparam int    PREFETCH_DEPTH           = 4;
    localparam int    PREFETCH_MAX_OUTSTANDING = 2;
    localparam word_t WORD_BYTES               = 32'd4;

    // What happens to a response beat arriving this cycle
    typedef enum logic [1:0] {
        BEAT_NONE,
        BEAT_PUSH,
        BEAT_DROP,
        BEAT_ORPHAN
    } beat_kind_t;

    function automatic word_t next_word(input word_t addr);
        return addr + WORD_BYTES;
    endfunction

endpackage

// File: rtl/text_memory_prefetch_interface_if.sv
// Pipelined in-order instruction bus: the prefetcher is master, memory is slave.
interface text_memory_prefetch_interface_if;
    import text_memory_prefetch_interface_pkg::*;

    word_t inst_address;
    logic  inst_read_enable;
    logic  inst_wait_req;
    logic  inst_valid;
    word_t inst_data;

    modport master (
        output inst_address,
        output inst_read_enable,
        input  inst_wait_req,
        input  inst_valid,
        input  inst_data
    );

    modport slave (
        input  inst_address,
        input  inst_read_enable,
        output inst_wait_req,
        output inst_valid,
        output inst_data
    );

endinterface

// File: rtl/text_memory_prefetch_interface_fifo.sv
// DEPTH x 32 synchronous FIFO holding prefetched words; head word is visible combinationally.
module prefetch_fifo
    import text_memory_prefetch_interface_pkg::*;
#(
    parameter  int DEPTH = PREFETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  word_t            push_data,
    input  logic             pop,
    output word_t            head_data,
    output logic [CNT_W-1:0] count
);

    word_t            storage [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            storage[tail_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = storage[head_ptr];

endmodule

// File: rtl/text_memory_prefetch_interface.sv
// Sequential instruction prefetcher between the core and a pipelined in-order bus.
// Any pc that differs from the buffered head is a redirect: flush and discard in-flight beats.
module text_memory_prefetch_interface
    import text_memory_prefetch_interface_pkg::*;
#(
    parameter int    DEPTH           = PREFETCH_DEPTH,
    parameter int    MAX_OUTSTANDING = PREFETCH_MAX_OUTSTANDING,
    parameter word_t RESET_PC        = INITIAL_PC
) (
    input  logic  clock,
    input  logic  reset,
    input  word_t pc,
    input  logic  next_inst,
    output logic  inst_available,
    output word_t inst,
    text_memory_prefetch_interface_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    word_t            head_pc;
    word_t            fetch_pc;
    logic [OUT_W-1:0] inflight;
    logic [OUT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    word_t            head_data;

    beat_kind_t       beat;
    logic             mismatch;
    logic             hit;
    logic             read_enable;
    logic             accept;
    logic             push;
    logic             pop;
    logic             beat_consumed;
    logic [OUT_W-1:0] flush_discard;

    always_comb begin
        beat = BEAT_NONE;
        if (bus.inst_valid) begin
            if (discard != '0) begin
                beat = BEAT_DROP;
            end else if (inflight != '0) begin
                beat = BEAT_PUSH;
            end else begin
                beat = BEAT_ORPHAN;
            end
        end
    end

    // Issue only while the buffer has a reserved slot for every request in flight
    always_comb begin
        mismatch      = (pc != head_pc);
        hit           = !reset && (count != '0) && !mismatch;
        read_enable   = !reset && !mismatch
                        && ((int'(count) + int'(inflight)) < DEPTH)
                        && ((int'(inflight) + int'(discard)) < MAX_OUTSTANDING);
        accept        = read_enable && !bus.inst_wait_req;
        push          = (beat == BEAT_PUSH) && !mismatch;
        pop           = next_inst && hit;
        beat_consumed = (beat == BEAT_PUSH) || (beat == BEAT_DROP);
        flush_discard = discard + inflight - OUT_W'(beat_consumed);
    end

    assign inst_available       = hit;
    assign inst                 = head_data;
    assign bus.inst_read_enable = read_enable;
    assign bus.inst_address     = fetch_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_pc  <= RESET_PC;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else if (mismatch) begin
            head_pc  <= pc;
            fetch_pc <= pc;
            inflight <= '0;
            discard  <= flush_discard;
        end else begin
            if (pop) begin
                head_pc <= next_word(head_pc);
            end
            if (accept) begin
                fetch_pc <= next_word(fetch_pc);
            end
            inflight <= inflight + OUT_W'(accept) - OUT_W'(push);
            if (beat == BEAT_DROP) begin
                discard <= discard - OUT_W'(1);
            end
        end
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (mismatch),
        .push      (push),
        .push_data (bus.inst_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    // A beat with nothing outstanding means the bus broke its ordering contract
    orphan_beat_check: assert property (@(posedge clock) disable iff (reset) beat != BEAT_ORPHAN);

endmodule

// File: tb/tb_text_memory_prefetch_interface.sv
// Self-checking bench: startup vector table, directed redirect/stall/wrap sequences and
// randomized bus timing, all compared against a queue-based model of the prefetcher.
module tb_text_memory_prefetch_interface;
    import text_memory_prefetch_interface_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic  clock = 1'b0;
    logic  reset;
    word_t pc;
    logic  next_inst;
    logic  inst_available;
    word_t inst;

    text_memory_prefetch_interface_if bus_if();

    text_memory_prefetch_interface #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (INITIAL_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .next_inst      (next_inst),
        .inst_available (inst_available),
        .inst           (inst),
        .bus            (bus_if.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        word_t addr;
        int    due;
        bit    stale;
    } req_t;

    typedef struct {
        word_t pc;
        logic  next_inst;
        logic  exp_avail;
        logic  exp_re;
        word_t exp_addr;
    } vec_t;

    // Model: requests on the bus and words sitting in the buffer, both as plain queues
    req_t  busq[$];
    word_t bufq[$];
    word_t m_head;
    word_t m_fetch;
    word_t core_pc;
    int    cyc;
    int    checks;
    int    errors;
    int    dut_retired;

    logic  act_avail;
    word_t act_inst;
    logic  act_re;
    word_t act_addr;
    logic  exp_avail;

    function automatic word_t mem_word(input word_t addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int live_requests();
        int n = 0;
        foreach (busq[i]) if (!busq[i].stale) n++;
        return n;
    endfunction

    task automatic checkOutput(input string name, input word_t actual, input word_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input word_t p, input logic ni, input logic wr, input int lat);
        logic  beat_now;
        logic  mismatch;
        logic  exp_re;
        int    due;
        req_t  r;
        @(negedge clock);
        reset                = 1'b0;
        pc                   = p;
        next_inst            = ni;
        bus_if.inst_wait_req = wr;
        beat_now             = (busq.size() > 0) && (busq[0].due == cyc);
        bus_if.inst_valid    = beat_now;
        bus_if.inst_data     = beat_now ? mem_word(busq[0].addr) : word_t'($urandom);
        #1;
        act_avail = inst_available;
        act_inst  = inst;
        act_re    = bus_if.inst_read_enable;
        act_addr  = bus_if.inst_address;
        if (act_avail && ni) dut_retired++;

        mismatch  = (p != m_head);
        exp_avail = !mismatch && (bufq.size() > 0);
        exp_re    = !mismatch && ((bufq.size() + live_requests()) < DEPTH) && (busq.size() < MAX_OUT);
        checkOutput("inst_available", word_t'(act_avail), word_t'(exp_avail));
        checkOutput("inst_read_enable", word_t'(act_re), word_t'(exp_re));
        if (exp_re) checkOutput("inst_address", act_addr, m_fetch);
        if (exp_avail) checkOutput("inst", act_inst, mem_word(p));

        if (beat_now) begin
            r = busq.pop_front();
            if (!r.stale && !mismatch) bufq.push_back(r.addr);
        end
        if (mismatch) begin
            bufq.delete();
            foreach (busq[i]) busq[i].stale = 1'b1;
            m_head  = p;
            m_fetch = p;
        end else begin
            if (ni && exp_avail) begin
                void'(bufq.pop_front());
                m_head = m_head + 32'd4;
            end
            if (exp_re && !wr) begin
                due = cyc + lat;
                if (busq.size() > 0 && busq[$].due >= due) due = busq[$].due + 1;
                busq.push_back('{m_fetch, due, 1'b0});
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(posedge clock);
        cyc++;
    endtask

    task automatic core_cycle(input logic ni, input logic wr, input int lat);
        applyStimulus(core_pc, ni, wr, lat);
        if (ni && exp_avail) core_pc = core_pc + 32'd4;
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        pc                   = INITIAL_PC;
        next_inst            = 1'b0;
        bus_if.inst_wait_req = 1'b0;
        bus_if.inst_valid    = 1'b0;
        bus_if.inst_data     = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            checkOutput("reset inst_available", word_t'(inst_available), 32'd0);
            checkOutput("reset inst_read_enable", word_t'(bus_if.inst_read_enable), 32'd0);
            @(posedge clock);
        end
        busq.delete();
        bufq.delete();
        m_head  = INITIAL_PC;
        m_fetch = INITIAL_PC;
        core_pc = INITIAL_PC;
        cyc     = 0;
    endtask

    vec_t  vecs[6];
    word_t got[$];
    word_t wrap_exp[3];
    int    base;
    bit    found;

    initial begin
        checks      = 0;
        errors      = 0;
        dut_retired = 0;
        cyc         = 0;
        reset       = 1'b1;
        pc          = INITIAL_PC;
        next_inst   = 1'b0;
        bus_if.inst_wait_req = 1'b0;
        bus_if.inst_valid    = 1'b0;
        bus_if.inst_data     = '0;

        vecs[0] = '{INITIAL_PC,          1'b1, 1'b0, 1'b1, INITIAL_PC};
        vecs[1] = '{INITIAL_PC,          1'b1, 1'b0, 1'b1, INITIAL_PC + 32'd4};
        vecs[2] = '{INITIAL_PC,          1'b1, 1'b1, 1'b1, INITIAL_PC + 32'd8};
        vecs[3] = '{INITIAL_PC + 32'd4,  1'b1, 1'b1, 1'b1, INITIAL_PC + 32'd12};
        vecs[4] = '{INITIAL_PC + 32'd8,  1'b1, 1'b1, 1'b1, INITIAL_PC + 32'd16};
        vecs[5] = '{INITIAL_PC + 32'd12, 1'b1, 1'b1, 1'b1, INITIAL_PC + 32'd20};

        do_reset();

        // Startup with a one-cycle bus: first word two cycles after reset release
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].next_inst, 1'b0, 1);
            checkOutput("vec inst_available", word_t'(act_avail), word_t'(vecs[i].exp_avail));
            checkOutput("vec inst_read_enable", word_t'(act_re), word_t'(vecs[i].exp_re));
            checkOutput("vec inst_address", act_addr, vecs[i].exp_addr);
            if (vecs[i].exp_avail) checkOutput("vec inst", act_inst, mem_word(vecs[i].pc));
        end
        core_pc = INITIAL_PC + 32'd16;
        for (int i = 0; i < 12; i++) core_cycle(1'b1, 1'b0, 1);
        checkOutput("sequential retired words", 32'(dut_retired), 32'd16);

        // Core stall: requests stop once the buffer is fully reserved
        for (int i = 0; i < 10; i++) core_cycle(1'b0, 1'b0, 1);
        checkOutput("stall inst_read_enable", word_t'(act_re), 32'd0);
        checkOutput("stall inst_available", word_t'(act_avail), 32'd1);
        for (int i = 0; i < 8; i++) core_cycle(1'b1, 1'b0, 1);

        // Redirect with two live beats in flight and none arriving that cycle
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busq.size() == 2 && live_requests() == 2 && busq[0].due != cyc) found = 1'b1;
            else core_cycle(1'b1, 1'b0, 3);
        end
        checkOutput("two in flight reached", word_t'(found), 32'd1);
        core_pc = 32'h0040_0040;
        core_cycle(1'b1, 1'b0, 3);
        checkOutput("redirect inst_available", word_t'(act_avail), 32'd0);
        checkOutput("redirect inst_read_enable", word_t'(act_re), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            core_cycle(1'b1, 1'b0, 1);
            if (act_re) found = 1'b1;
        end
        checkOutput("redirect request issued", word_t'(found), 32'd1);
        checkOutput("redirect first address", act_addr, 32'h0040_0040);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            core_cycle(1'b1, 1'b0, 1);
            if (act_avail) found = 1'b1;
        end
        checkOutput("redirect word available", word_t'(found), 32'd1);
        checkOutput("redirect word", act_inst, mem_word(32'h0040_0040));

        // Redirect in the same cycle a live beat arrives
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busq.size() > 0 && busq[0].due == cyc && !busq[0].stale) found = 1'b1;
            else core_cycle(1'b1, 1'b0, 2);
        end
        checkOutput("live beat due reached", word_t'(found), 32'd1);
        core_pc = 32'h0040_1000;
        core_cycle(1'b1, 1'b0, 2);
        checkOutput("same-cycle redirect inst_available", word_t'(act_avail), 32'd0);
        for (int i = 0; i < 12; i++) core_cycle(1'b1, 1'b0, 2);

        // Random bus stalls, latency and core behaviour
        base = dut_retired;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) core_pc = word_t'($urandom) & 32'hFFFF_FFFC;
            core_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end
        checkOutput("random progress", word_t'(dut_retired - base > 40), 32'd1);

        // Address wrap past the top of memory
        core_pc = 32'hFFFF_FFF8;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        for (int i = 0; i < 16; i++) begin
            core_cycle(1'b1, 1'b0, 1);
            if (act_re) got.push_back(act_addr);
        end
        checkOutput("wrap request count", word_t'(got.size() >= 3), 32'd1);
        if (got.size() >= 3) begin
            for (int i = 0; i < 3; i++) checkOutput("wrap request address", got[i], wrap_exp[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
